// File: rtl/geofence_pkg.sv
// Shared types and width helpers for the geofence_n convex-polygon engine.
package geofence_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        CAL  = 2'd2,
        OUT  = 2'd3
    } state_e;

    // Signed cross product of two (CW+1)-bit differences: two 2CW+2 products and one subtraction.
    function automatic int cross_width(input int cw);
        return 2 * cw + 3;
    endfunction

    // Number of (i, j) pairs visited by the angular sort around vertex 0.
    function automatic int sort_cycles(input int nv);
        return (nv - 1) * (nv - 2) / 2;
    endfunction

endpackage

// File: rtl/geofence_cross.sv
// Combinational signed cross product a x b, reduced to sign and zero flags.
module geofence_cross
    import geofence_pkg::*;
#(
    parameter int CW = 10
) (
    input  logic signed [CW:0] ax,
    input  logic signed [CW:0] ay,
    input  logic signed [CW:0] bx,
    input  logic signed [CW:0] by,
    output logic               neg,
    output logic               zero
);

    localparam int PW = 2 * CW + 2;
    localparam int XW = cross_width(CW);

    logic signed [PW-1:0] p_ab;
    logic signed [PW-1:0] p_ba;
    logic signed [XW-1:0] c;

    always_comb begin
        p_ab = PW'(ax) * PW'(by);
        p_ba = PW'(ay) * PW'(bx);
        c    = XW'(p_ab) - XW'(p_ba);
        neg  = c[XW-1];
        zero = (c == '0);
    end

endmodule

// File: rtl/geofence_n.sv
// Convex-polygon geofence: loads a target and NV vertices, sorts the vertices CCW
// around vertex 0, then classifies the target as inside / on boundary / outside.
module geofence_n
    import geofence_pkg::*;
#(
    parameter int CW = 10,
    parameter int NV = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [CW-1:0] X,
    input  logic [CW-1:0] Y,
    output logic          ready,
    output logic          valid,
    output logic          is_inside,
    output logic          on_edge
);

    localparam int VW   = $clog2(NV);
    localparam int CNTW = $clog2(NV + 1);
    localparam logic [VW-1:0]   V_LAST   = VW'(NV - 1);
    localparam logic [VW-1:0]   V_PEN    = VW'(NV - 2);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NV);

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [VW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic [CW-1:0]   tx_q, tx_d, ty_q, ty_d;
    logic [CW-1:0]   vx_q [NV];
    logic [CW-1:0]   vx_d [NV];
    logic [CW-1:0]   vy_q [NV];
    logic [CW-1:0]   vy_d [NV];
    logic            neg_any_q, neg_any_d, zero_any_q, zero_any_d;
    logic            inside_q, inside_d, on_edge_q, on_edge_d;

    logic               accept;
    logic [VW-1:0]      a_idx, b_idx, k_next, beat_idx;
    logic [CW-1:0]      org_x, org_y;
    logic signed [CW:0] ax, ay, bx, by;
    logic               c_neg, c_zero;

    // One cross-product unit: SORT compares two vertices around v[0], CAL walks edges around T.
    always_comb begin
        k_next = (k_q == V_LAST) ? '0 : k_q + VW'(1);
        if (state_q == CAL) begin
            a_idx = k_q;
            b_idx = k_next;
            org_x = tx_q;
            org_y = ty_q;
        end else begin
            a_idx = i_q;
            b_idx = j_q;
            org_x = vx_q[0];
            org_y = vy_q[0];
        end
        ax = {1'b0, vx_q[a_idx]} - {1'b0, org_x};
        ay = {1'b0, vy_q[a_idx]} - {1'b0, org_y};
        bx = {1'b0, vx_q[b_idx]} - {1'b0, org_x};
        by = {1'b0, vy_q[b_idx]} - {1'b0, org_y};
    end

    geofence_cross #(.CW(CW)) u_cross (
        .ax   (ax),
        .ay   (ay),
        .bx   (bx),
        .by   (by),
        .neg  (c_neg),
        .zero (c_zero)
    );

    assign ready     = (state_q == LOAD) && reset;
    assign accept    = in_valid && ready;
    assign beat_idx  = VW'(cnt_q - CNTW'(1));
    assign valid     = (state_q == OUT);
    assign is_inside = inside_q;
    assign on_edge   = on_edge_q;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        vx_d       = vx_q;
        vy_d       = vy_q;
        neg_any_d  = neg_any_q;
        zero_any_d = zero_any_q;
        inside_d   = inside_q;
        on_edge_d  = on_edge_q;

        case (state_q)
            LOAD: begin
                if (accept) begin
                    if (cnt_q == '0) begin
                        tx_d = X;
                        ty_d = Y;
                    end else begin
                        vx_d[beat_idx] = X;
                        vy_d[beat_idx] = Y;
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = SORT;
                        cnt_d   = '0;
                        i_d     = VW'(1);
                        j_d     = VW'(2);
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            SORT: begin
                if (c_neg) begin
                    vx_d[i_q] = vx_q[j_q];
                    vy_d[i_q] = vy_q[j_q];
                    vx_d[j_q] = vx_q[i_q];
                    vy_d[j_q] = vy_q[i_q];
                end
                if (j_q == V_LAST) begin
                    if (i_q == V_PEN) begin
                        state_d    = CAL;
                        k_d        = '0;
                        neg_any_d  = 1'b0;
                        zero_any_d = 1'b0;
                    end else begin
                        i_d = i_q + VW'(1);
                        j_d = i_q + VW'(2);
                    end
                end else begin
                    j_d = j_q + VW'(1);
                end
            end
            CAL: begin
                neg_any_d  = neg_any_q | c_neg;
                zero_any_d = zero_any_q | c_zero;
                k_d        = k_next;
                if (k_q == V_LAST) begin
                    state_d   = OUT;
                    inside_d  = !(neg_any_q | c_neg);
                    on_edge_d = !(neg_any_q | c_neg) && (zero_any_q | c_zero);
                end
            end
            OUT:     state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= LOAD;
            cnt_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            neg_any_q  <= 1'b0;
            zero_any_q <= 1'b0;
            inside_q   <= 1'b0;
            on_edge_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            neg_any_q  <= neg_any_d;
            zero_any_q <= zero_any_d;
            inside_q   <= inside_d;
            on_edge_q  <= on_edge_d;
        end
    end

    // NOTE: coordinate storage is not reset; every entry is rewritten in LOAD before it is read.
    always_ff @(posedge clk) begin
        tx_q <= tx_d;
        ty_q <= ty_d;
        vx_q <= vx_d;
        vy_q <= vy_d;
    end

endmodule

// File: doc/geofence_n.md
# geofence_n

Parametrised convex-polygon geofence engine. Per transaction it accepts one target point and NV polygon vertices in arbitrary angular order. It sorts the vertices angularly around vertex 0 using signed cross products, then classifies the target as inside, on the boundary, or outside. It is the next generation of the fixed 6-vertex geofence: vertex count and coordinate width are configurable, a true cross product replaces the sign stub, an input handshake is added, and boundary detection is new.

## Interface
- CW, 10, coordinate width in bits; coordinates are unsigned.
- NV, 6, polygon vertex count, legal range 3..8.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  X/Y beat valid.
- X  in  CW  x coordinate of the current beat.
- Y  in  CW  y coordinate of the current beat.
- ready  out  1  beat acceptance; high only in LOAD and only while reset is high.
- valid  out  1  one-cycle result strobe; reset value 0.
- is_inside  out  1  target is inside or on the boundary; reset value 0.
- on_edge  out  1  target lies on the boundary (edge or vertex); reset value 0.

## Operation
- Beats are accepted on edges where in_valid and ready are both high.
- Beat 0 is the target (TX, TY). Beats 1..NV are vertices v[0..NV-1]. Stalls on in_valid may occur between any beats.
- States:
  - LOAD: accept NV+1 beats. On acceptance of beat NV, go to SORT.
  - SORT: step through pair (i, j) for i = 1..NV-2, j = i+1..NV-1, one pair per cycle, i outer. Compute c = cross(v[i]-v[0], v[j]-v[0]). If c < 0, swap v[i] and v[j]; the swap is visible to the next pair. This takes S = (NV-1)(NV-2)/2 cycles. The result is counter-clockwise order.
  - CAL: for k = 0..NV-1, one per cycle, compute c_k = cross(v[k]-T, v[(k+1) mod NV]-T). Record pos_k = (c_k > 0) and zero_k = (c_k == 0). Takes NV cycles.
  - OUT: one cycle. valid = 1. is_inside = no c_k < 0. on_edge = is_inside AND any zero_k. Then go to LOAD.
- Outside a convex polygon, at least one c_k is negative, including points on an edge's line extension, so no extra segment check is required.
- Arithmetic:
  - Differences are signed, CW+1 bits.
  - Each product is signed, 2CW+2 bits.
  - The cross product is signed, 2CW+3 bits.
  - No truncation or saturation at any stage.
- is_inside and on_edge hold their value until the next OUT or reset. valid is high only in OUT.
- Degenerate input (collinear or duplicate vertices) is not flagged. The result is whatever the sign rules above produce.

## Timing
- Let t be the edge at which beat NV is accepted.
- SORT occupies cycles t+1..t+S. CAL occupies t+S+1..t+S+NV. valid is high in cycle t+S+NV+1.
- For NV=6, valid is high in cycle t+17.
- ready drops in cycle t+1 and rises again in the cycle after valid. The next target beat may be accepted on that edge, so back-to-back transactions are supported.
- Reset low at any edge:
  - state goes to LOAD and the beat counter and pair indices go to 0;
  - valid, is_inside and on_edge go to 0;
  - any in-flight transaction is discarded;
  - ready is 0 while reset is low.
- Beats presented while ready is low are ignored and not stored.

## Structure
- Package geofence_pkg holds:
  - the state enum (LOAD, SORT, CAL, OUT);
  - a width helper giving cross width = 2*CW+3;
  - the sort-cycle constant S computed from NV.
- Sub-module geofence_cross: a combinational signed cross product of two CW+1-bit difference vectors. It outputs neg and zero flags. A single instance is shared by SORT and CAL through an operand mux.
- Vertex storage is a register array of NV entries; swaps write both entries in one cycle.

## Test plan
- Inside case, NV=6, CW=10: target (5,5), vertices (8,10),(2,0),(0,5),(10,5),(2,10),(8,0) -> valid 17 cycles after the last beat, is_inside=1, on_edge=0.
- Outside case: same polygon, target (20,20) -> is_inside=0, on_edge=0. Target (12,0), on the extension of the bottom edge line -> is_inside=0, on_edge=0.
- Boundary case: target (5,0) -> is_inside=1, on_edge=1. Target (2,0), equal to a vertex -> is_inside=1, on_edge=1.
- Width extremes: triangle (0,0),(1023,0),(0,1023) with target (511,511) -> is_inside=1, on_edge=0, with no overflow. Target (512,512) -> is_inside=0.
- Handshake and reset:
  - in_valid toggled every other cycle during LOAD -> same result as the unstalled run;
  - back-to-back transactions -> the next target is accepted on the edge after valid;
  - reset low mid-SORT -> ready=0 and valid=0 during reset, no stale valid afterwards, and a fresh transaction completes correctly.
- Parameter sweep: NV=3 triangle -> valid 5 cycles after the last beat (S=1, CAL=3). NV=8 octagon -> valid 30 cycles after the last beat.
